uart_alu_cmd_ctrl: RTL and testbench
====================================

// Module: uart_alu_cmd_ctrl
// PURPOSE
//  Parametrised command controller between the UART RX/TX FIFOs and the ALU.
//  Assembles multi-byte operands A, B and one opcode byte from the RX FIFO, and drives them to the ALU.
//  Registers the ALU result and streams it back through the TX FIFO, LSB byte first.
//  Adds a stalled-command timeout, TX backpressure and a one-hot state/flag output.
// PARAMETERS
//  DBIT            8   UART/FIFO data width in bits.
//  BUS_SIZE        8   ALU operand/result width; multiple of DBIT; NB = BUS_SIZE/DBIT bytes per operand.
//  OP_SIZE         6   ALU opcode width (<= DBIT); taken from low bits of opcode byte, upper bits ignored.
//  TIMEOUT_CYCLES  0   idle cycles allowed mid-command before abort; 0 = timeout disabled.
// PORTS
//  clk             in   1         system clock, all logic on rising edge
//  i_reset         in   1         asynchronous reset, active-high
//  i_rx_data       in   DBIT      RX FIFO head data (first-word-fall-through, valid while ~i_rx_empty)
//  i_rx_empty      in   1         RX FIFO empty
//  o_rd            out  1         RX FIFO pop, 1-cycle pulse per byte consumed
//  i_tx_full       in   1         TX FIFO full
//  o_wr            out  1         TX FIFO push, 1-cycle pulse per byte
//  o_tx_data       out  DBIT      byte pushed with o_wr
//  o_op_a          out  BUS_SIZE  ALU operand A
//  o_op_b          out  BUS_SIZE  ALU operand B
//  o_opcode        out  OP_SIZE   ALU opcode
//  i_alu_result    in   BUS_SIZE  ALU combinational result
//  o_flags         out  6         one-hot state: [0]IDLE [1]GET_A [2]GET_B [3]GET_OP [4]CALC [5]SEND
//  o_timeout       out  1         1-cycle pulse when a command is aborted on timeout
//  o_err           out  1         sticky; set on timeout, cleared when next command completes SEND
// BEHAVIOUR
//  Reset: state IDLE, o_flags=6'b000001, o_rd=o_wr=0, o_tx_data=0, o_op_a=o_op_b=0, o_opcode=0.
//  Reset also clears: o_timeout=0, o_err=0, byte counter=0, timeout counter=0, result reg=0.
//  Reset mid-operation discards any partial command or unsent result; no o_wr after reset deasserts.
//  Byte read: in any RX state, if ~i_rx_empty then o_rd=1 that cycle and i_rx_data captured same edge.
//  RX bytes may be consumed back-to-back, one per cycle.
//  Operand bytes arrive LSB first; byte k lands in bits [k*DBIT +: DBIT].
//  o_op_a and o_op_b update as bytes arrive and hold until overwritten by the next command.
//  IDLE: on read, capture A byte 0; go to GET_A with cnt=1, or to GET_B with cnt=0 if NB==1.
//  GET_A: capture A bytes 1..NB-1; after byte NB-1 go to GET_B, cnt=0.
//  GET_B: capture NB bytes; after the last, go to GET_OP.
//  GET_OP: capture one byte, o_opcode = byte[OP_SIZE-1:0]; go to CALC.
//  CALC: exactly 1 cycle; result reg <= i_alu_result; go to SEND, cnt=0.
//  SEND: each cycle with ~i_tx_full, o_wr=1, o_tx_data=result[cnt*DBIT +: DBIT], cnt++.
//  SEND with i_tx_full=1 gives o_wr=0 and holds cnt; the byte is never dropped or duplicated.
//  After byte NB-1 is pushed, clear o_err and go to IDLE.
//  SEND ignores RX: o_rd stays 0 even if the RX FIFO is non-empty.
//  Latency: last opcode read to first o_wr is 2 cycles with TX not full (CALC, then SEND).
//  Timeout, TIMEOUT_CYCLES>0 only: counter active in GET_A/GET_B/GET_OP; resets to 0 on every o_rd.
//  Timeout count: increments each cycle with no read; when it reaches TIMEOUT_CYCLES, go to IDLE.
//  On timeout abort: o_timeout=1 for that cycle, o_err=1, partial bytes discarded, cnt=0.
//  IDLE, CALC and SEND never time out.
//  Timeout reached in the same cycle as a read: the read wins, the counter resets and there is no abort.
//  o_timeout and o_rd are never high together.
//  Counter widths are $clog2-sized: byte counter holds NB-1, timeout counter holds TIMEOUT_CYCLES.
//  Counters never wrap.
// TESTING
//  T1 BUS_SIZE=8: RX 0x05,0x03,0x20, ALU stub returns 0x08 -> o_op_a=05, o_op_b=03, o_opcode=0x20.
//     T1 TX output: exactly one o_wr with 0x08, two cycles after the opcode o_rd; o_flags returns to 000001.
//  T2 BUS_SIZE=16: RX 34,12,01,00,20 -> o_op_a=0x1234, o_op_b=0x0001; stub 0x1235 -> TX 0x35 then 0x12.
//  T3 backpressure: hold i_tx_full=1 for 5 cycles in SEND -> no o_wr during those cycles.
//     T3 after release: bytes are sent in order, none lost or repeated.
//  T4 TIMEOUT_CYCLES=16: send only A, then RX empty -> o_timeout pulse 16 cycles after last o_rd.
//     T4 after abort: state IDLE and o_err=1; a full valid command then completes and clears o_err.
//  T5 assert i_reset mid-GET_B and separately mid-SEND -> all outputs reach reset values immediately (async).
//     T5 after reset: no further o_wr until a new command.
//  T6 RX non-empty continuously -> o_rd back-to-back in GET_* states, no o_rd in CALC/SEND.

Source files
------------

// File: rtl/uart_alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_cmd_ctrl
//   Command controller between the UART RX/TX FIFOs and an ALU. It assembles
//   operand A (NB bytes), operand B (NB bytes) and one opcode byte from the RX
//   FIFO. It drives them to the ALU, registers the ALU result for one cycle and
//   streams the result back through the TX FIFO, least significant byte first.
//   An optional timeout aborts a command that stalls part way through.
//
// Handshake (both FIFOs): the RX FIFO is first-word-fall-through. i_rx_data is
//   valid whenever i_rx_empty is low. o_rd pops exactly the byte captured on
//   the same rising edge. A byte is written into the TX FIFO on every cycle
//   where o_wr is high, and o_wr is only raised while i_tx_full is low.
//
// Ports
//   clk           system clock, rising edge
//   i_reset       asynchronous reset, active high
//   i_rx_data     RX FIFO head byte
//   i_rx_empty    RX FIFO empty
//   o_rd          RX FIFO pop, one pulse per consumed byte
//   i_tx_full     TX FIFO full
//   o_wr          TX FIFO push, one pulse per byte
//   o_tx_data     byte pushed with o_wr
//   o_op_a/o_op_b ALU operands (BUS_SIZE bits)
//   o_opcode      ALU opcode (OP_SIZE bits)
//   i_alu_result  combinational ALU result
//   o_flags       one-hot state: [0]IDLE [1]GET_A [2]GET_B [3]GET_OP [4]CALC [5]SEND
//   o_timeout     one-cycle pulse when a command is aborted on timeout
//   o_err         sticky timeout error, cleared when a command finishes SEND
// -----------------------------------------------------------------------------
module uart_alu_cmd_ctrl #(
  parameter int DBIT           = 8,
  parameter int BUS_SIZE       = 8,
  parameter int OP_SIZE        = 6,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic [DBIT-1:0]     i_rx_data,
  input  logic                i_rx_empty,
  output logic                o_rd,
  input  logic                i_tx_full,
  output logic                o_wr,
  output logic [DBIT-1:0]     o_tx_data,
  output logic [BUS_SIZE-1:0] o_op_a,
  output logic [BUS_SIZE-1:0] o_op_b,
  output logic [OP_SIZE-1:0]  o_opcode,
  input  logic [BUS_SIZE-1:0] i_alu_result,
  output logic [5:0]          o_flags,
  output logic                o_timeout,
  output logic                o_err
);

  localparam int NB    = BUS_SIZE / DBIT;
  localparam int CW    = (NB > 1) ? $clog2(NB) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int TW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
  // The abort fires on the idle cycle that would bring the count to
  // TIMEOUT_CYCLES, so the register itself never has to hold that value.
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  // Encoding order matches the o_flags bit positions.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GET_A  = 3'd1,
    S_GET_B  = 3'd2,
    S_GET_OP = 3'd3,
    S_CALC   = 3'd4,
    S_SEND   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       to_cnt_q, to_cnt_d;
  logic [BUS_SIZE-1:0] op_a_q, op_a_d;
  logic [BUS_SIZE-1:0] op_b_q, op_b_d;
  logic [OP_SIZE-1:0]  opcode_q, opcode_d;
  logic [BUS_SIZE-1:0] result_q, result_d;
  logic                err_q, err_d;

  logic rx_state;
  logic get_state;
  logic rd;
  logic wr;
  logic timeout;

  // Replace byte idx of vec with b, leaving the other bytes untouched.
  function automatic logic [BUS_SIZE-1:0] put_byte(input logic [BUS_SIZE-1:0] vec,
                                                   input logic [CW-1:0]       idx,
                                                   input logic [DBIT-1:0]     b);
    int sh;
    sh = int'(idx) * DBIT;
    return (vec & ~(BUS_SIZE'({DBIT{1'b1}}) << sh)) | (BUS_SIZE'(b) << sh);
  endfunction

  assign get_state = (state_q == S_GET_A) || (state_q == S_GET_B) ||
                     (state_q == S_GET_OP);
  assign rx_state  = (state_q == S_IDLE) || get_state;
  // Gated by reset so the pop strobe is low while reset is held, even if
  // the RX FIFO still holds data.
  assign rd        = rx_state && !i_rx_empty && !i_reset;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    to_cnt_d = '0;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    opcode_d = opcode_q;
    result_d = result_q;
    err_d    = err_q;
    wr       = 1'b0;
    timeout  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rd) begin
          op_a_d = put_byte(op_a_q, '0, i_rx_data);
          if (NB == 1) begin
            state_d = S_GET_B;
            cnt_d   = '0;
          end else begin
            state_d = S_GET_A;
            cnt_d   = CW'(1);
          end
        end
      end
      S_GET_A: begin
        if (rd) begin
          op_a_d = put_byte(op_a_q, cnt_q, i_rx_data);
          if (cnt_q == LAST_BYTE) begin
            state_d = S_GET_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_GET_B: begin
        if (rd) begin
          op_b_d = put_byte(op_b_q, cnt_q, i_rx_data);
          if (cnt_q == LAST_BYTE) begin
            state_d = S_GET_OP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_GET_OP: begin
        if (rd) begin
          opcode_d = i_rx_data[OP_SIZE-1:0];
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        result_d = i_alu_result;
        state_d  = S_SEND;
        cnt_d    = '0;
      end
      S_SEND: begin
        // Backpressure just holds cnt, so the pending byte is re-offered.
        if (!i_tx_full) begin
          wr = 1'b1;
          if (cnt_q == LAST_BYTE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Stall timeout. A read in the same cycle always wins: rd keeps the
    // counter at its cleared default and skips the abort.
    if (TO_EN && get_state && !rd) begin
      if (to_cnt_q == TO_LAST) begin
        timeout  = 1'b1;
        state_d  = S_IDLE;
        cnt_d    = '0;
        err_d    = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      to_cnt_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      opcode_q <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      to_cnt_q <= to_cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign o_rd      = rd;
  assign o_wr      = wr;
  assign o_timeout = timeout;
  assign o_tx_data = DBIT'(result_q >> (int'(cnt_q) * DBIT));
  assign o_op_a    = op_a_q;
  assign o_op_b    = op_b_q;
  assign o_opcode  = opcode_q;
  assign o_err     = err_q;
  assign o_flags   = 6'b000001 << state_q;

endmodule

// File: tb/tb_uart_alu_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_cmd_ctrl
//   Two instances share one set of FIFO models. dut16 has BUS_SIZE=16 and
//   TIMEOUT_CYCLES=16. dut8 has BUS_SIZE=8 and the timeout disabled. sel
//   routes the RX FIFO and the observed outputs to one instance; the other
//   instance sees an empty RX FIFO and stays idle.
// -----------------------------------------------------------------------------
module tb_uart_alu_cmd_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic       sel;            // 0: dut16, 1: dut8
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       tx_full;
  logic [15:0] alu16;
  logic [7:0]  alu8;

  // ---------------- dut16 ----------------
  logic        rd16, wr16, to16, err16;
  logic [7:0]  txd16;
  logic [15:0] opa16, opb16;
  logic [5:0]  opc16, flags16;

  uart_alu_cmd_ctrl #(.DBIT(8), .BUS_SIZE(16), .OP_SIZE(6), .TIMEOUT_CYCLES(16)) dut16 (
    .clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_empty(rx_empty | sel),
    .o_rd(rd16), .i_tx_full(tx_full), .o_wr(wr16), .o_tx_data(txd16),
    .o_op_a(opa16), .o_op_b(opb16), .o_opcode(opc16), .i_alu_result(alu16),
    .o_flags(flags16), .o_timeout(to16), .o_err(err16)
  );

  // ---------------- dut8 ----------------
  logic        rd8, wr8, to8, err8;
  logic [7:0]  txd8, opa8, opb8;
  logic [5:0]  opc8, flags8;

  uart_alu_cmd_ctrl #(.DBIT(8), .BUS_SIZE(8), .OP_SIZE(6), .TIMEOUT_CYCLES(0)) dut8 (
    .clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_empty(rx_empty | ~sel),
    .o_rd(rd8), .i_tx_full(tx_full), .o_wr(wr8), .o_tx_data(txd8),
    .o_op_a(opa8), .o_op_b(opb8), .o_opcode(opc8), .i_alu_result(alu8),
    .o_flags(flags8), .o_timeout(to8), .o_err(err8)
  );

  // ---------------- observed (selected) outputs ----------------
  logic        rd, wr, tout, err;
  logic [7:0]  txd;
  logic [15:0] opa, opb;
  logic [5:0]  opc, flags;

  assign rd    = sel ? rd8    : rd16;
  assign wr    = sel ? wr8    : wr16;
  assign tout  = sel ? to8    : to16;
  assign err   = sel ? err8   : err16;
  assign txd   = sel ? txd8   : txd16;
  assign opa   = sel ? {8'h00, opa8} : opa16;
  assign opb   = sel ? {8'h00, opb8} : opb16;
  assign opc   = sel ? opc8   : opc16;
  assign flags = sel ? flags8 : flags16;

  localparam logic [5:0] F_IDLE  = 6'b000001;
  localparam logic [5:0] F_GET_B = 6'b000100;

  // ---------------- scoreboard state ----------------
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int to_seen = 0;
  int to_cyc = 0;
  int last_rd_cyc = 0;
  int op_rd_cyc = 0;
  int first_wr_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic rx_sync();
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rx_q[0];
  endtask

  // One clock cycle: sample outputs at the falling edge, then advance the
  // FIFO model just after the rising edge.
  task automatic step();
    logic rd_now;
    @(negedge clk);
    cyc++;
    rd_now = rd;
    if (!rx_empty && (flags[3:0] != 4'b0000)) check("rd_when_avail", {31'b0, rd}, 32'd1);
    if (flags[4] || flags[5]) check("no_rd_calc_send", {31'b0, rd}, 32'd0);
    check("rd_timeout_excl", {31'b0, rd & tout}, 32'd0);
    check("wr_while_full", {31'b0, wr & tx_full}, 32'd0);
    if (tout) begin
      to_seen++;
      to_cyc = cyc;
    end
    if (rd) begin
      rd_cnt++;
      last_rd_cyc = cyc;
      if (flags[3]) op_rd_cyc = cyc;
    end
    if (wr) begin
      if (wr_cnt == 0) first_wr_cyc = cyc;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got byte %0h expected no write (cycle %0d)", txd, cyc);
      end else begin
        check("tx_byte", {24'b0, txd}, {24'b0, exp_q.pop_front()});
      end
    end
    @(posedge clk);
    #1;
    if (rd_now) void'(rx_q.pop_front());
    rx_sync();
  endtask

  task automatic push_cmd(input int nb, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] op_byte, input logic [15:0] alu);
    for (int i = 0; i < nb; i++) rx_q.push_back(a[i*8 +: 8]);
    for (int i = 0; i < nb; i++) rx_q.push_back(b[i*8 +: 8]);
    rx_q.push_back(op_byte);
    for (int i = 0; i < nb; i++) exp_q.push_back(alu[i*8 +: 8]);
    alu16 = alu;
    alu8  = alu[7:0];
    rx_sync();
  endtask

  // Run until nb bytes were written and the DUT is back in IDLE. tx_full is
  // held for the first `stall` cycles spent in SEND.
  task automatic wait_done(input int nb, input int stall, input int budget);
    int stall_left;
    stall_left = stall;
    wr_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      if (flags[5] && stall_left > 0) begin
        tx_full = 1'b1;
        stall_left--;
      end else begin
        tx_full = 1'b0;
      end
      step();
      if (wr_cnt == nb && flags == F_IDLE) break;
    end
    tx_full = 1'b0;
    check("wr_count", wr_cnt, nb);
    check("latency", first_wr_cyc - op_rd_cyc, 2 + stall);
    check("exp_q_empty", exp_q.size(), 0);
    check("flags_idle", {26'b0, flags}, {26'b0, F_IDLE});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rd"},    {31'b0, rd},    32'd0);
    check({tag, "_wr"},    {31'b0, wr},    32'd0);
    check({tag, "_flags"}, {26'b0, flags}, {26'b0, F_IDLE});
    check({tag, "_txd"},   {24'b0, txd},   32'd0);
    check({tag, "_opa"},   {16'b0, opa},   32'd0);
    check({tag, "_opb"},   {16'b0, opb},   32'd0);
    check({tag, "_opc"},   {26'b0, opc},   32'd0);
    check({tag, "_tout"},  {31'b0, tout},  32'd0);
    check({tag, "_err"},   {31'b0, err},   32'd0);
  endtask

  // ---------------- vector table (dut16) ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  op_byte;
    logic [15:0] alu;
    logic [5:0]  exp_opc;
    int          stall;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{a: 16'h1234, b: 16'h0001, op_byte: 8'h20, alu: 16'h1235, exp_opc: 6'h20, stall: 0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h8001, op_byte: 8'hE5, alu: 16'h7F80, exp_opc: 6'h25, stall: 0};
    vecs[2] = '{a: 16'h0000, b: 16'hFFFF, op_byte: 8'h3F, alu: 16'hA55A, exp_opc: 6'h3F, stall: 5};
    vecs[3] = '{a: 16'h00FF, b: 16'hFF00, op_byte: 8'hC0, alu: 16'h0102, exp_opc: 6'h00, stall: 2};

    rst = 1'b1;
    sel = 1'b0;
    tx_full = 1'b0;
    alu16 = 16'h0;
    alu8 = 8'h0;
    rx_sync();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset16");
    sel = 1'b1;
    #1;
    check_reset_vals("reset8");
    sel = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven commands on dut16 (includes backpressure rows).
    for (int v = 0; v < 4; v++) begin
      push_cmd(2, vecs[v].a, vecs[v].b, vecs[v].op_byte, vecs[v].alu);
      wait_done(2, vecs[v].stall, 40);
      check("vec_opa", {16'b0, opa}, {16'b0, vecs[v].a});
      check("vec_opb", {16'b0, opb}, {16'b0, vecs[v].b});
      check("vec_opc", {26'b0, opc}, {26'b0, vecs[v].exp_opc});
      check("vec_err", {31'b0, err}, 32'd0);
    end

    // Two commands queued at once: back-to-back reads in RX states only.
    rd_cnt = 0;
    push_cmd(2, 16'h0201, 16'h0403, 8'h05, 16'hBEEF);
    push_cmd(2, 16'h0706, 16'h0908, 8'h0A, 16'hBEEF);
    wr_cnt = 0;
    repeat (20) step();
    check("b2b_reads", rd_cnt, 10);
    check("b2b_writes", wr_cnt, 4);
    check("b2b_opa", {16'b0, opa}, 32'h0706);
    check("b2b_exp_empty", exp_q.size(), 0);

    // Timeout abort: only operand A arrives.
    to_seen = 0;
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    rx_sync();
    for (int i = 0; i < 40; i++) begin
      step();
      if (to_seen > 0) break;
    end
    check("timeout_seen", to_seen, 1);
    check("timeout_delay", to_cyc - last_rd_cyc, 16);
    check("timeout_flags", {26'b0, flags}, {26'b0, F_IDLE});
    check("timeout_err", {31'b0, err}, 32'd1);

    // Read on the 16th idle cycle beats the timeout; the command then
    // completes and clears the error.
    rx_q.push_back(8'h33);
    rx_q.push_back(8'h44);
    rx_sync();
    repeat (2) step();
    repeat (15) step();
    check("near_timeout_none", to_seen, 1);
    check("near_timeout_state", {26'b0, flags}, {26'b0, F_GET_B});
    check("near_timeout_err", {31'b0, err}, 32'd1);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h00);
    exp_q.push_back(8'h78);
    exp_q.push_back(8'h56);
    alu16 = 16'h5678;
    rx_sync();
    wait_done(2, 0, 40);
    check("read_wins_no_abort", to_seen, 1);
    check("err_cleared", {31'b0, err}, 32'd0);
    check("read_wins_opa", {16'b0, opa}, 32'h4433);

    // Async reset in GET_B with a byte still waiting in the RX FIFO.
    push_cmd(2, 16'hBBAA, 16'hDDCC, 8'h01, 16'h0000);
    repeat (3) step();
    check("pre_reset_state", {26'b0, flags}, {26'b0, F_GET_B});
    #2 rst = 1'b1;
    #1;
    check_reset_vals("rst_getb");
    rx_q.delete();
    exp_q.delete();
    rx_sync();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_cnt = 0;
    repeat (10) step();
    check("getb_post_reset_wr", wr_cnt, 0);

    // Async reset in SEND while the TX FIFO is full.
    push_cmd(2, 16'h0001, 16'h0002, 8'h03, 16'hABCD);
    tx_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (flags[5]) break;
    end
    repeat (2) step();
    check("pre_reset_send", {26'b0, flags}, 32'h20);
    check("pre_reset_txd", {24'b0, txd}, 32'hCD);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("rst_send");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tx_full = 1'b0;
    wr_cnt = 0;
    repeat (10) step();
    check("send_post_reset_wr", wr_cnt, 0);

    // dut8: single-byte operands, timeout disabled.
    sel = 1'b1;
    #1;
    push_cmd(1, 16'h0005, 16'h0003, 8'h20, 16'h0008);
    wait_done(1, 0, 20);
    check("t1_opa", {16'b0, opa}, 32'h05);
    check("t1_opb", {16'b0, opb}, 32'h03);
    check("t1_opc", {26'b0, opc}, 32'h20);

    to_seen = 0;
    rx_q.push_back(8'h07);
    rx_sync();
    repeat (40) step();
    check("no_timeout_when_disabled", to_seen, 0);
    check("disabled_stays_getb", {26'b0, flags}, {26'b0, F_GET_B});
    rx_q.push_back(8'h09);
    rx_q.push_back(8'hC1);
    exp_q.push_back(8'h10);
    alu8 = 8'h10;
    rx_sync();
    wait_done(1, 0, 20);
    check("t1b_opa", {16'b0, opa}, 32'h07);
    check("t1b_opc", {26'b0, opc}, 32'h01);
    check("t1b_err", {31'b0, err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
